// File: rtl/pulse_arbiter_pkg.sv
// pulse_arbiter_pkg
//   Shared types and default constants for the pulse_arbiter block.
//   - state_t      : arbiter FSM state encoding (IDLE=0, PULSE=1, GAP=2)
//   - DEF_N        : default number of requesters
//   - DEF_PULSE_LEN: default number of cycles x stays high per grant
//   GAP is only reachable when PULSE_ARBITER_GAP_EN is defined.
package pulse_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int unsigned DEF_N         = 4;
    localparam int unsigned DEF_PULSE_LEN = 3;

endpackage

// File: rtl/pulse_arbiter_if.sv
// pulse_arbiter_if
//   Request/grant bundle between the requesters and pulse_arbiter.
//   Signals:
//   - req_n : per-requester request, active-low, level-sensitive
//   - x     : shared output pulse
//   - gnt   : one-hot grant, held for the whole pulse
//   - done  : one-cycle completion flag to the granted requester
//   - busy  : arbiter not idle
//   Modports:
//   - master : requester side (drives req_n)
//   - slave  : arbiter side (drives x, gnt, done, busy)
interface pulse_arbiter_if
    import pulse_arbiter_pkg::*;
#(
    parameter int unsigned N = DEF_N
) ();

    logic [N-1:0] req_n;
    logic         x;
    logic [N-1:0] gnt;
    logic [N-1:0] done;
    logic         busy;

    modport master (
        output req_n,
        input  x,
        input  gnt,
        input  done,
        input  busy
    );

    modport slave (
        input  req_n,
        output x,
        output gnt,
        output done,
        output busy
    );

endinterface

// File: rtl/pulse_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin picker: selects the first active request at
//   or after ptr, wrapping modulo N.
//   Ports:
//   - req    in  N  : request vector, active-high
//   - ptr    in  PW : search start index
//   - onehot out N  : one-hot winner (zero when nothing is requested)
//   - idx    out PW : winner index (zero when nothing is requested)
//   - any    out 1  : at least one request is active
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [PW-1:0] idx,
    output logic          any
);

    logic        found;
    int unsigned j;

    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        j      = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (32'(ptr) + k) % N;
            if (!found && req[j]) begin
                found     = 1'b1;
                onehot[j] = 1'b1;
                idx       = PW'(j);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/pulse_arbiter.sv
// pulse_arbiter
//   Shares one fixed-width output pulse between N active-low requesters
//   using round-robin arbitration. A winner picked in IDLE gets x=1 and a
//   held one-hot gnt for PULSE_LEN cycles; done mirrors gnt in the last
//   pulse cycle. Requests are sampled only in IDLE, and a started pulse
//   always runs to completion unless clr is asserted.
//   Parameters:
//   - N         : number of requesters (>=2)
//   - PULSE_LEN : cycles x stays high per grant (>=1)
//   Ports:
//   - clk : clock, rising edge
//   - clr : synchronous active-low reset
//   - bus : pulse_arbiter_if slave (req_n in; x, gnt, done, busy out)
//   Build option:
//   - PULSE_ARBITER_GAP_EN : when defined, a one-cycle GAP state follows
//     every pulse, so x stays low for at least 2 cycles between pulses.
module pulse_arbiter
    import pulse_arbiter_pkg::*;
#(
    parameter int unsigned N         = DEF_N,
    parameter int unsigned PULSE_LEN = DEF_PULSE_LEN
) (
    input  logic                  clk,
    input  logic                  clr,
    pulse_arbiter_if.slave        bus
);

    localparam int unsigned PW = $clog2(N);
    localparam int unsigned CW = ($clog2(PULSE_LEN) > 1) ? $clog2(PULSE_LEN) : 1;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic          x_r;
    logic [N-1:0]  gnt_r;

    logic [N-1:0]  pick_oh;
    logic [PW-1:0] pick_idx;
    logic          pick_any;

    rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .req    (~bus.req_n),
        .ptr    (ptr),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_ff @(posedge clk) begin
        if (!clr) begin
            state <= IDLE;
            cnt   <= '0;
            ptr   <= '0;
            win   <= '0;
            x_r   <= 1'b0;
            gnt_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        gnt_r <= pick_oh;
                        x_r   <= 1'b1;
                        cnt   <= CW'(PULSE_LEN - 1);
                        win   <= pick_idx;
                        state <= PULSE;
                    end
                end
                PULSE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        x_r   <= 1'b0;
                        gnt_r <= '0;
                        // Pointer advances past the winner only once its
                        // pulse has fully completed.
                        ptr   <= (win == PW'(N - 1)) ? '0 : win + PW'(1);
`ifdef PULSE_ARBITER_GAP_EN
                        state <= GAP;
`else
                        state <= IDLE;
`endif
                    end
                end
`ifdef PULSE_ARBITER_GAP_EN
                GAP: begin
                    state <= IDLE;
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.x    = x_r;
    assign bus.gnt  = gnt_r;
    assign bus.done = (state == PULSE && cnt == '0) ? gnt_r : '0;
    assign bus.busy = (state != IDLE);

endmodule

// File: tb/tb_pulse_arbiter.sv
// tb_pulse_arbiter
//   Directed self-checking bench for pulse_arbiter: reset, single request,
//   round-robin contention, early release, pointer wrap, reset mid-pulse,
//   and a PULSE_LEN=1 instance. Honours PULSE_ARBITER_GAP_EN.
module tb_pulse_arbiter;

`ifdef PULSE_ARBITER_GAP_EN
    localparam bit GAP_ON = 1'b1;
`else
    localparam bit GAP_ON = 1'b0;
`endif

    logic clk;
    logic clr;

    int n_pass;
    int n_total;

    pulse_arbiter_if #(.N(4)) bus3 ();
    pulse_arbiter_if #(.N(4)) bus1 ();

    pulse_arbiter #(.N(4), .PULSE_LEN(3)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus3.slave)
    );

    pulse_arbiter #(.N(4), .PULSE_LEN(1)) dut1 (
        .clk (clk),
        .clr (clr),
        .bus (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk3(input string tag, input logic ex, input logic [3:0] eg,
                        input logic [3:0] ed, input logic eb);
        chk({tag, ".x"},    32'(bus3.x),    32'(ex));
        chk({tag, ".gnt"},  32'(bus3.gnt),  32'(eg));
        chk({tag, ".done"}, 32'(bus3.done), 32'(ed));
        chk({tag, ".busy"}, 32'(bus3.busy), 32'(eb));
    endtask

    task automatic chk1(input string tag, input logic ex, input logic [3:0] eg,
                        input logic [3:0] ed, input logic eb);
        chk({tag, ".x"},    32'(bus1.x),    32'(ex));
        chk({tag, ".gnt"},  32'(bus1.gnt),  32'(eg));
        chk({tag, ".done"}, 32'(bus1.done), 32'(ed));
        chk({tag, ".busy"}, 32'(bus1.busy), 32'(eb));
    endtask

    // Called just after the granting edge: checks the three pulse cycles
    // and the first cycle after the falling edge, leaving time at the IDLE
    // cycle that follows the pulse.
    task automatic pulse3(input string tag, input logic [3:0] g);
        chk3({tag, "_c0"}, 1'b1, g, 4'b0000, 1'b1);
        tick();
        chk3({tag, "_c1"}, 1'b1, g, 4'b0000, 1'b1);
        tick();
        chk3({tag, "_c2"}, 1'b1, g, g, 1'b1);
        tick();
        chk3({tag, "_lo"}, 1'b0, 4'b0000, 4'b0000, GAP_ON);
        if (GAP_ON) tick();
    endtask

    initial begin
        n_pass      = 0;
        n_total     = 0;
        clr         = 1'b0;
        bus3.req_n  = 4'b1111;
        bus1.req_n  = 4'b1111;

        // Reset
        tick();
        tick();
        chk3("reset", 1'b0, 4'b0000, 4'b0000, 1'b0);
        chk1("reset1", 1'b0, 4'b0000, 4'b0000, 1'b0);
        clr = 1'b1;
        tick();
        chk3("idle_noreq", 1'b0, 4'b0000, 4'b0000, 1'b0);

        // Single request on index 0, released right after the grant
        bus3.req_n = 4'b1110;
        tick();
        bus3.req_n = 4'b1111;
        pulse3("single", 4'b0001);
        tick();
        chk3("single_noregrant", 1'b0, 4'b0000, 4'b0000, 1'b0);

        // Reset so contention starts from ptr=0
        clr = 1'b0;
        tick();
        clr = 1'b1;

        // Contention: all four held low
        bus3.req_n = 4'b0000;
        tick();
        pulse3("cont0", 4'b0001);
        tick();
        pulse3("cont1", 4'b0010);
        tick();
        pulse3("cont2", 4'b0100);
        tick();
        pulse3("cont3", 4'b1000);
        tick();
        bus3.req_n = 4'b1111;
        pulse3("cont4", 4'b0001);
        tick();
        chk3("cont_idle", 1'b0, 4'b0000, 4'b0000, 1'b0);

        // Early release: index 2 low for one cycle (ptr=1 -> index 2 wins)
        bus3.req_n = 4'b1011;
        tick();
        bus3.req_n = 4'b1111;
        pulse3("early", 4'b0100);
        tick();
        chk3("early_noregrant", 1'b0, 4'b0000, 4'b0000, 1'b0);

        // Wrap: ptr=3, requests on 0 and 2 -> index 0 wins, ptr becomes 1
        bus3.req_n = 4'b1010;
        tick();
        bus3.req_n = 4'b1111;
        pulse3("wrap", 4'b0001);
        // ptr=1: same request pattern now picks index 2
        bus3.req_n = 4'b1010;
        tick();
        bus3.req_n = 4'b1111;
        pulse3("after_wrap", 4'b0100);

        // Reset mid-pulse: ptr=3, all requesting -> index 3 wins
        bus3.req_n = 4'b0000;
        tick();
        chk3("rst_mid_c0", 1'b1, 4'b1000, 4'b0000, 1'b1);
        tick();
        chk3("rst_mid_c1", 1'b1, 4'b1000, 4'b0000, 1'b1);
        clr = 1'b0;
        tick();
        chk3("rst_mid_cleared", 1'b0, 4'b0000, 4'b0000, 1'b0);
        clr = 1'b1;
        tick();
        bus3.req_n = 4'b1111;
        pulse3("rst_ptr0", 4'b0001);

        // PULSE_LEN=1 instance: index 3
        bus1.req_n = 4'b0111;
        tick();
        bus1.req_n = 4'b1111;
        chk1("len1_pulse", 1'b1, 4'b1000, 4'b1000, 1'b1);
        tick();
        chk1("len1_after", 1'b0, 4'b0000, 4'b0000, GAP_ON);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
